// File: rtl/cpu_oci_debug_mem_ctrl.sv
// System-clock side of the JTAG ocimem debug path: on-chip debug RAM shared with a CPU Avalon-MM slave.
// Optional OCIMEM_CPU_WPROT_EN: CPU writes only take effect while debugack is high.
module cpu_oci_debug_mem_ctrl #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AVS_AW = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic [AVS_AW-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   ram_q;
    logic [8:0]          ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic                ram_we;

    logic                pend_valid;
    logic                pend_wr;
    logic [8:0]          pend_addr;
    logic [DATA_W-1:0]   pend_data;
    logic [8:0]          mon_areg;

    logic                pend_in_range;
    logic                avs_in_range;
    logic                busy;
    logic                j_svc;
    logic                j_wr_done;
    logic                j_oor;
    logic                c_rd_issue;
    logic                c_oor;
    logic [DATA_W-1:0]   rd_hold;
    logic [DATA_W-1:0]   c_rd_data;

    logic                cmd_req;
    logic                cmd_wr;
    logic [8:0]          cmd_addr;

    logic                cpu_wr_allow;
    logic                unused_bits;

`ifdef OCIMEM_CPU_WPROT_EN
    assign cpu_wr_allow = debugack;
    assign unused_bits  = ^{jdo[37:36], jdo[2:0]};
`else
    assign cpu_wr_allow = 1'b1;
    assign unused_bits  = ^{jdo[37:36], jdo[2:0], debugack};
`endif

    assign pend_in_range = 32'(pend_addr) < DEPTH;
    assign avs_in_range  = 32'(avs_address) < DEPTH;
    assign busy          = pend_valid | (state == J_RD);

    // Single-port RAM, read-first, one cycle read latency.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[RAM_AW-1:0]] <= ram_wdata;
        end
        ram_q <= mem[ram_addr[RAM_AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A queued JTAG op always wins the RAM port over the CPU.
    always_comb begin
        state_nxt       = state;
        ram_addr        = pend_addr;
        ram_wdata       = pend_data;
        ram_we          = 1'b0;
        avs_waitrequest = 1'b0;
        j_svc           = 1'b0;
        j_wr_done       = 1'b0;
        j_oor           = 1'b0;
        c_rd_issue      = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    avs_waitrequest = avs_read | avs_write;
                    j_svc           = 1'b1;
                    if (!pend_in_range) begin
                        j_oor = 1'b1;
                    end else if (pend_wr) begin
                        ram_we    = 1'b1;
                        j_wr_done = 1'b1;
                    end else begin
                        state_nxt = J_RD;
                    end
                end else if (avs_write) begin
                    ram_addr  = 9'(avs_address);
                    ram_wdata = avs_writedata;
                    ram_we    = avs_in_range & cpu_wr_allow;
                end else if (avs_read) begin
                    ram_addr        = 9'(avs_address);
                    avs_waitrequest = 1'b1;
                    c_rd_issue      = 1'b1;
                    state_nxt       = C_RD;
                end
            end
            J_RD: begin
                avs_waitrequest = avs_read | avs_write;
                state_nxt       = IDLE;
            end
            C_RD: begin
                avs_waitrequest = avs_write;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign c_rd_data    = c_oor ? '0 : ram_q;
    assign avs_readdata = (state == C_RD) ? c_rd_data : rd_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_oor   <= 1'b0;
            rd_hold <= '0;
        end else begin
            if (c_rd_issue) begin
                c_oor <= !avs_in_range;
            end
            if (state == C_RD) begin
                rd_hold <= c_rd_data;
            end
        end
    end

    always_comb begin
        cmd_req  = 1'b0;
        cmd_wr   = 1'b0;
        cmd_addr = mon_areg;
        if (take_action_ocimem_a) begin
            cmd_req  = jdo[35] & jdo[34];
            cmd_addr = jdo[25:17];
        end else if (take_action_ocimem_b) begin
            cmd_req = 1'b1;
            cmd_wr  = 1'b1;
        end else if (take_no_action_ocimem_a) begin
            cmd_req = 1'b1;
        end
    end

    // Later assignments win: an incoming command overrides completion status from the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid    <= 1'b0;
            pend_wr       <= 1'b0;
            pend_addr     <= '0;
            pend_data     <= '0;
            mon_areg      <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (j_svc) begin
                pend_valid <= 1'b0;
                mon_areg   <= pend_addr + 9'd1;
            end
            if (j_wr_done) begin
                monitor_ready <= 1'b1;
            end
            if (j_oor) begin
                monitor_ready <= 1'b1;
                monitor_error <= 1'b1;
            end
            if (state == J_RD) begin
                MonDReg       <= ram_q;
                monitor_ready <= 1'b1;
            end
            if (take_action_ocimem_a) begin
                if (jdo[35]) begin
                    mon_areg <= jdo[25:17];
                end else begin
                    monitor_ready <= 1'b0;
                    monitor_error <= 1'b0;
                end
            end
            if (cmd_req) begin
                if (busy) begin
                    monitor_ready <= 1'b1;
                    monitor_error <= 1'b1;
                end else begin
                    pend_valid    <= 1'b1;
                    pend_wr       <= cmd_wr;
                    pend_addr     <= cmd_addr;
                    pend_data     <= jdo[34:3];
                    monitor_ready <= 1'b0;
                    monitor_error <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_oci_debug_mem_ctrl.sv
// Self-checking bench: directed scenarios plus randomized ops against a word-level reference model.
module tb_cpu_oci_debug_mem_ctrl;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_b, take_n;
    logic        debugack;
    logic [8:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    cpu_oci_debug_mem_ctrl #(.DEPTH(DEPTH), .DATA_W(32), .AVS_AW(9)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_n),
        .debugack                (debugack),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] ref_mem [DEPTH];
    int unsigned mon_a;
    logic [31:0] exp_mon;
    logic        exp_rdy, exp_err;
    logic [31:0] exp_rd_hold;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cpu_wr_en();
`ifdef OCIMEM_CPU_WPROT_EN
        return debugack;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [8:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 9'($urandom_range(DEPTH, 511));
        return 9'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_rdy"}, 32'(monitor_ready), 32'(exp_rdy));
        chk({tag, "_err"}, 32'(monitor_error), 32'(exp_err));
        chk({tag, "_mon"}, MonDReg, exp_mon);
    endtask

    task automatic avs_wr(input logic [8:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        #1;
        chk("avs_wr_wait", 32'(avs_waitrequest), 32'd0);
        if (a < DEPTH && cpu_wr_en()) ref_mem[a] = d;
        cyc();
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [8:0] a);
        avs_address = a; avs_read = 1'b1;
        #1;
        chk("avs_rd_wait1", 32'(avs_waitrequest), 32'd1);
        cyc();
        exp_rd_hold = (a < DEPTH) ? ref_mem[a] : 32'd0;
        chk("avs_rd_wait0", 32'(avs_waitrequest), 32'd0);
        chk("avs_rd_data", avs_readdata, exp_rd_hold);
        cyc();
        avs_read = 1'b0;
        #1;
        chk("avs_rd_hold", avs_readdata, exp_rd_hold);
    endtask

    // Model of one accepted JTAG RAM op from pulse edge to completion.
    task automatic jtag_access(input bit is_wr, input logic [31:0] d);
        int unsigned addr;
        addr  = mon_a;
        mon_a = (mon_a + 1) % 512;
        chk("acc_rdy0", 32'(monitor_ready), 32'd0);
        chk("acc_err0", 32'(monitor_error), 32'd0);
        if (addr >= DEPTH) begin
            cyc();
            exp_rdy = 1'b1; exp_err = 1'b1;
        end else if (is_wr) begin
            ref_mem[addr] = d;
            cyc();
            exp_rdy = 1'b1; exp_err = 1'b0;
        end else begin
            cyc();
            chk("rd_latency", 32'(monitor_ready), 32'd0);
            cyc();
            exp_mon = ref_mem[addr];
            exp_rdy = 1'b1; exp_err = 1'b0;
        end
        check_status("acc");
    endtask

    // kind: 0 set addr, 1 set addr+read, 2 write, 3 read-next, 4 clear status
    task automatic jtag_cmd(input int kind, input logic [8:0] a, input logic [31:0] d);
        jdo = 38'({$urandom(), $urandom()});
        case (kind)
            0, 1: begin jdo[35] = 1'b1; jdo[34] = (kind == 1); jdo[25:17] = a; take_a = 1'b1; end
            2:    begin jdo[34:3] = d; take_b = 1'b1; end
            3:    take_n = 1'b1;
            default: begin jdo[35] = 1'b0; take_a = 1'b1; end
        endcase
        cyc();
        take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
        case (kind)
            0: begin mon_a = a; check_status("setaddr"); end
            1: begin mon_a = a; jtag_access(1'b0, d); end
            2: jtag_access(1'b1, d);
            3: jtag_access(1'b0, d);
            default: begin exp_rdy = 1'b0; exp_err = 1'b0; check_status("clear"); end
        endcase
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        reset_n = 1'b0; jdo = '0; take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
        debugack = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        mon_a = 0; exp_mon = '0; exp_rdy = 1'b0; exp_err = 1'b0; exp_rd_hold = '0;
        repeat (3) cyc();
        chk("rst_mon", MonDReg, 32'd0);
        chk("rst_rdy", 32'(monitor_ready), 32'd0);
        chk("rst_err", 32'(monitor_error), 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_wait", 32'(avs_waitrequest), 32'd0);
        reset_n = 1'b1;
        cyc();

        for (int i = 0; i < DEPTH; i++) avs_wr(9'(i), $urandom());

        // MonAReg starts at 0
        jtag_cmd(3, '0, '0);

        // set address / write / set+read, then read-next proves MonAReg=6
        jtag_cmd(0, 9'd5, '0);
        jtag_cmd(2, '0, 32'hDEADBEEF);
        jtag_cmd(1, 9'd5, '0);
        chk("deadbeef", MonDReg, 32'hDEADBEEF);
        jtag_cmd(3, '0, '0);

        // boundary and wrap of the address register
        jtag_cmd(0, 9'd255, '0);
        jtag_cmd(3, '0, '0);
        jtag_cmd(3, '0, '0);
        chk("bound_mon", MonDReg, ref_mem[255]);
        jtag_cmd(4, '0, '0);
        jtag_cmd(0, 9'd511, '0);
        jtag_cmd(2, '0, 32'h0BAD0BAD);
        jtag_cmd(3, '0, '0);

        // CPU read against a pending JTAG write
        jtag_cmd(0, 9'd3, '0);
        d = $urandom();
        jdo = 38'({$urandom(), $urandom()}); jdo[34:3] = d; take_b = 1'b1;
        cyc();
        take_b = 1'b0;
        avs_address = 9'd3; avs_read = 1'b1;
        #1;
        chk("conf_wait_pend", 32'(avs_waitrequest), 32'd1);
        chk("conf_rdy0", 32'(monitor_ready), 32'd0);
        cyc();
        ref_mem[3] = d; mon_a = 4; exp_rdy = 1'b1; exp_err = 1'b0;
        chk("conf_rdy1", 32'(monitor_ready), 32'd1);
        chk("conf_wait_issue", 32'(avs_waitrequest), 32'd1);
        cyc();
        chk("conf_wait0", 32'(avs_waitrequest), 32'd0);
        chk("conf_rdata", avs_readdata, d);
        cyc();
        avs_read = 1'b0;

        // overrun: read-next on two consecutive cycles
        jtag_cmd(0, 9'd10, '0);
        jdo = 38'({$urandom(), $urandom()}); take_n = 1'b1;
        cyc();
        chk("ovr_rdy0", 32'(monitor_ready), 32'd0);
        chk("ovr_err0", 32'(monitor_error), 32'd0);
        cyc();
        take_n = 1'b0;
        chk("ovr_drop_rdy", 32'(monitor_ready), 32'd1);
        chk("ovr_drop_err", 32'(monitor_error), 32'd1);
        cyc();
        mon_a = 11; exp_mon = ref_mem[10]; exp_rdy = 1'b1; exp_err = 1'b1;
        check_status("ovr_done");
        jtag_cmd(3, '0, '0);

        // CPU write protection and out-of-range CPU accesses
        debugack = 1'b1;
        avs_wr(9'd0, 32'hA5A50000);
        debugack = 1'b0;
        avs_wr(9'd0, 32'h00001234);
        avs_rd(9'd0);
        debugack = 1'b1;
        avs_wr(9'd0, 32'h00001234);
        avs_rd(9'd0);
        avs_wr(9'd300, $urandom());
        avs_rd(9'd300);

        // reset in the middle of a JTAG read
        jtag_cmd(0, 9'd20, '0);
        jdo = 38'({$urandom(), $urandom()}); take_n = 1'b1;
        cyc();
        take_n = 1'b0;
        reset_n = 1'b0;
        #1;
        mon_a = 0; exp_mon = '0; exp_rdy = 1'b0; exp_err = 1'b0;
        check_status("midrst");
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        check_status("postrst");
        jtag_cmd(3, '0, '0);

        // randomized mix of JTAG and CPU operations
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 6))
                0: jtag_cmd(0, rand_addr(), '0);
                1: jtag_cmd(1, rand_addr(), '0);
                2: jtag_cmd(2, '0, $urandom());
                3: jtag_cmd(3, '0, '0);
                4: begin debugack = 1'($urandom()); avs_wr(rand_addr(), $urandom()); end
                5: avs_rd(rand_addr());
                default: jtag_cmd(4, '0, '0);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
